// File: rtl/pdm_cic_decim.sv
// Multi-channel 3rd-order CIC decimator: 1-bit PDM in, channel-multiplexed PCM out.
// Build option CIC_WARMUP_SUPPRESS_EN hides the first three frames after reset.
module pdm_cic_decim #(
  parameter int NUM_MICS   = 9,
  parameter int DEC_FACTOR = 64,
  parameter int OUT_WIDTH  = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pdm_en,
  input  logic [NUM_MICS-1:0]  pdm,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [3:0]           out_channel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [7:0]           overrun_count
);
  localparam int CW = $clog2(DEC_FACTOR);

  typedef logic [OUT_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  word_t r_i1 [NUM_MICS];
  word_t r_i2 [NUM_MICS];
  word_t r_i3 [NUM_MICS];
  word_t r_snap [NUM_MICS];
  word_t r_d1 [NUM_MICS];
  word_t r_d2 [NUM_MICS];
  word_t r_d3 [NUM_MICS];
  word_t w_i1n [NUM_MICS];
  word_t w_i2n [NUM_MICS];
  word_t w_i3n [NUM_MICS];

  logic [CW-1:0] r_dec_cnt;
  state_t        r_state;
  logic [3:0]    r_ch;

  word_t w_s, w_c1, w_c2, w_c3;
  logic  w_tick, w_last, w_hs, w_accept, w_ovr, w_emit;

  always_comb begin
    for (int i = 0; i < NUM_MICS; i++) begin
      w_i1n[i] = r_i1[i] + {{(OUT_WIDTH-1){1'b0}}, pdm[i]};
      w_i2n[i] = r_i2[i] + w_i1n[i];
      w_i3n[i] = r_i3[i] + w_i2n[i];
    end
  end

  // Time-shared comb stage for the channel currently in LOAD
  assign w_s  = r_snap[r_ch];
  assign w_c1 = w_s - r_d1[r_ch];
  assign w_c2 = w_c1 - r_d2[r_ch];
  assign w_c3 = w_c2 - r_d3[r_ch];

  assign w_tick = pdm_en && (&r_dec_cnt);
  assign w_last = (r_ch == 4'(NUM_MICS-1));
  assign w_hs   = (r_state == S_SEND) && out_ready;
  // A tick landing on the final handshake starts the next frame directly
  assign w_accept = w_tick && ((r_state == S_IDLE) || (w_hs && w_last));

`ifdef CIC_WARMUP_SUPPRESS_EN
  logic [1:0] r_warm;
  assign w_emit = (r_warm == 2'd3);
  assign w_ovr  = w_tick && !w_accept && w_emit;
`else
  assign w_emit = 1'b1;
  assign w_ovr  = w_tick && !w_accept;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MICS; i++) begin
        r_i1[i]   <= '0;
        r_i2[i]   <= '0;
        r_i3[i]   <= '0;
        r_snap[i] <= '0;
        r_d1[i]   <= '0;
        r_d2[i]   <= '0;
        r_d3[i]   <= '0;
      end
      r_dec_cnt         <= '0;
      r_state           <= S_IDLE;
      r_ch              <= '0;
      out_data          <= '0;
      out_channel       <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      overrun_count     <= '0;
`ifdef CIC_WARMUP_SUPPRESS_EN
      r_warm            <= '0;
`endif
    end else begin
      if (pdm_en) begin
        r_dec_cnt <= r_dec_cnt + CW'(1);
        for (int i = 0; i < NUM_MICS; i++) begin
          r_i1[i] <= w_i1n[i];
          r_i2[i] <= w_i2n[i];
          r_i3[i] <= w_i3n[i];
        end
      end
      if (w_accept) begin
        for (int i = 0; i < NUM_MICS; i++)
          r_snap[i] <= w_i3n[i];
      end
      if (w_ovr && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_LOAD;
            r_ch    <= '0;
          end
        end
        S_LOAD: begin
          r_d1[r_ch]        <= w_s;
          r_d2[r_ch]        <= w_c1;
          r_d3[r_ch]        <= w_c2;
          out_data          <= w_c3;
          out_channel       <= r_ch;
          out_startofpacket <= (r_ch == 4'd0);
          out_endofpacket   <= w_last;
          if (w_emit) begin
            out_valid <= 1'b1;
            r_state   <= S_SEND;
          end else if (w_last) begin
            r_state <= S_IDLE;
`ifdef CIC_WARMUP_SUPPRESS_EN
            r_warm  <= r_warm + 2'd1;
`endif
          end else begin
            r_ch <= r_ch + 4'd1;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!w_last) begin
              r_ch    <= r_ch + 4'd1;
              r_state <= S_LOAD;
            end else if (w_accept) begin
              r_ch    <= '0;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Self-checking bench for pdm_cic_decim: frame-level CIC reference model
// feeding a scoreboard, plus a table of scenarios with steady-state checks.
module tb_pdm_cic_decim;
  localparam int NM = 9;
  localparam int R  = 64;
  localparam int W  = 19;
`ifdef CIC_WARMUP_SUPPRESS_EN
  localparam int WARM = 3;
`else
  localparam int WARM = 0;
`endif
  localparam int FT = WARM + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pdm_en;
  logic [NM-1:0] pdm;
  logic [W-1:0]  out_data;
  logic [3:0]    out_channel;
  logic          out_valid;
  logic          out_ready;
  logic          sop;
  logic          eop;
  logic [7:0]    overrun_count;

  always #5 clk = ~clk;

  pdm_cic_decim #(.NUM_MICS(NM), .DEC_FACTOR(R), .OUT_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .pdm_en(pdm_en),
    .pdm(pdm),
    .out_data(out_data),
    .out_channel(out_channel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_startofpacket(sop),
    .out_endofpacket(eop),
    .overrun_count(overrun_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   ch;
  } exp_t;
  exp_t q[$];

  logic [W-1:0] m_i1[NM], m_i2[NM], m_i3[NM];
  logic [W-1:0] m_d1[NM], m_d2[NM], m_d3[NM];
  logic [W-1:0] s, c1, c2, c3;
  logic [W-1:0] last_v[NM];
  logic [W-1:0] first_v;
  logic [W-1:0] held_d;
  logic [3:0]   held_c;
  int m_cnt, m_hs, m_warm;
  bit m_busy, got_first, prev_stall;
  exp_t e;

  // Reference: predicts what the next rising edge does, using stable inputs
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NM; i++) begin
        m_i1[i] = '0; m_i2[i] = '0; m_i3[i] = '0;
        m_d1[i] = '0; m_d2[i] = '0; m_d3[i] = '0;
        last_v[i] = '0;
      end
      m_cnt = 0; m_hs = 0; m_warm = 0;
      m_busy = 0; got_first = 0; prev_stall = 0;
      first_v = '0;
      q.delete();
    end else begin
      if (prev_stall && out_valid) begin
        n_tests++;
        if (out_data !== held_d || out_channel !== held_c) begin
          n_fail++;
          $display("FAIL hold: got %0d/ch%0d, want %0d/ch%0d",
                   out_data, out_channel, held_d, held_c);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_channel;

      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_sample: got %0d ch%0d, want none",
                   out_data, out_channel);
        end else begin
          e = q.pop_front();
          if (out_data !== e.data || out_channel !== e.ch ||
              sop !== (e.ch == 0) || eop !== (e.ch == NM-1)) begin
            n_fail++;
            $display("FAIL sample: got %0d ch%0d sop%b eop%b, want %0d ch%0d",
                     out_data, out_channel, sop, eop, e.data, e.ch);
          end
          last_v[e.ch] = out_data;
          if (!got_first && e.ch == 0) begin
            got_first = 1;
            first_v = out_data;
          end
        end
        m_hs++;
        if (m_hs == NM) begin
          m_hs = 0;
          m_busy = 0;
        end
      end

      if (pdm_en) begin
        for (int i = 0; i < NM; i++) begin
          m_i1[i] = m_i1[i] + W'(pdm[i]);
          m_i2[i] = m_i2[i] + m_i1[i];
          m_i3[i] = m_i3[i] + m_i2[i];
        end
        if (m_cnt == R-1) begin
          if (!m_busy) begin
            for (int i = 0; i < NM; i++) begin
              s  = m_i3[i];
              c1 = s - m_d1[i];
              c2 = c1 - m_d2[i];
              c3 = c2 - m_d3[i];
              m_d1[i] = s; m_d2[i] = c1; m_d3[i] = c2;
              if (m_warm >= WARM) begin
                e.data = c3;
                e.ch = 4'(i);
                q.push_back(e);
              end
            end
            if (m_warm < WARM) m_warm++;
            else m_busy = 1;
          end
        end
        m_cnt = (m_cnt + 1) % R;
      end
    end
  end

  typedef struct {
    string        name;
    int           mode;
    int           rdy;
    int           period;
    int           stall;
    int           ticks;
    logic [W-1:0] e_first;
    logic [W-1:0] e_on;
    logic [W-1:0] e_off;
    int           e_ovr;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pdm_en = 1'b0; pdm = '0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {out_valid, out_data, out_channel, sop, eop, overrun_count}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int total;
    bit alt;
    alt = 0;
    do_reset();
    total = v.ticks * R * v.period + 4;
    for (int c = 0; c < total; c++) begin
      pdm_en = ((c % v.period) == v.period - 1);
      if (v.mode == 0) pdm = '0;
      else if (v.mode == 1) pdm = '1;
      else if (v.mode == 2) begin
        if (pdm_en) begin
          pdm = alt ? '0 : '1;
          alt = !alt;
        end
      end else begin
        pdm = '0;
        pdm[3] = 1'b1;
      end
      if (v.rdy == 0) out_ready = 1'b1;
      else if (v.rdy == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (c >= v.stall);
      @(posedge clk);
      #1;
    end
    pdm_en = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check({v.name, "_drain"}, q.size(), 0);
    check({v.name, "_got_first"}, got_first, 1);
    check({v.name, "_first"}, first_v, v.e_first);
    check({v.name, "_ch3"}, last_v[3], v.e_on);
    check({v.name, "_ch0"}, last_v[0], v.e_off);
    check({v.name, "_ch8"}, last_v[8], v.e_off);
    check({v.name, "_ovr"}, overrun_count, v.e_ovr);
  endtask

  initial begin
    logic [W-1:0] ones_first, alt_first;
    bit seen;
    ones_first = (WARM != 0) ? 19'd262144 : 19'd45760;
    alt_first  = (WARM != 0) ? 19'd131072 : 19'd23408;
    tbl[0] = '{"ones",  1, 0, 1, 0, 8, ones_first, 19'd262144, 19'd262144, 0};
    tbl[1] = '{"zeros", 0, 0, 1, 0, 8, 19'd0, 19'd0, 19'd0, 0};
    tbl[2] = '{"alt",   2, 0, 1, 0, 8, alt_first, 19'd131072, 19'd131072, 0};
    tbl[3] = '{"mic3",  3, 1, 2, 0, 8, 19'd0, 19'd262144, 19'd0, 0};
    tbl[4] = '{"stall", 1, 2, 1, FT*R + 96, FT + 8,
               ones_first, 19'd262144, 19'd262144, 1};
    tbl[5] = '{"sat",   1, 2, 1, (FT + 260) * R, FT + 268,
               ones_first, 19'd262144, 19'd262144, 255};

    for (int k = 0; k < 6; k++) run_vec(tbl[k]);

    // Reset landing in the middle of a stalled frame
    do_reset();
    pdm = '1;
    pdm_en = 1'b1;
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = out_valid;
    end
    check("midreset_seen_valid", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset_valid", out_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    pdm_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
